// File: rtl/approx_mul_pipe_if.sv
// Operand/result handshake bundle for approx_mul_pipe: the operand stream in,
// the product stream out, plus the delivered-result counter and busy flag.
interface approx_mul_pipe_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   prod;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, prod, out_count, busy
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, prod, out_count, busy
    );
endinterface

// File: rtl/approx_mul_pipe.sv
// Three-stage approximate unsigned multiplier: operands are split into halves,
// low-order partial-product bits are dropped according to mode, and the rest summed.
module approx_mul_pipe #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    approx_mul_pipe_if.slave bus
);
    localparam int H = W / 2;
    localparam int P = 2 * W;
    localparam logic [W-1:0] LOW_H = {{(W-H){1'b0}}, {H{1'b1}}};
    localparam logic [W-1:0] LOW_Q = {{(W-H/2){1'b0}}, {(H/2){1'b1}}};

    logic             advance;
    logic             v1_reg, v2_reg, v3_reg;
    logic [W-1:0]     a1_reg, b1_reg;
    logic [1:0]       mode1_reg;
    logic [W-1:0]     pp_raw  [4];
    logic [W-1:0]     pp_next [4];
    logic [W-1:0]     pp_reg  [4];
    logic [P-1:0]     prod_next, prod_reg;
    logic [CNT_W-1:0] count_reg;

    // Partial product index: bit 1 selects the high half of a, bit 0 of b
    // (0 = ll, 1 = lh, 2 = hl, 3 = hh).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pp
            logic [H-1:0] half_a;
            logic [H-1:0] half_b;
            assign half_a     = (gi >= 2)     ? a1_reg[W-1:H] : a1_reg[H-1:0];
            assign half_b     = (gi % 2 == 1) ? b1_reg[W-1:H] : b1_reg[H-1:0];
            assign pp_raw[gi] = {{H{1'b0}}, half_a} * {{H{1'b0}}, half_b};
        end
    endgenerate

    always_comb begin
        pp_next = pp_raw;
        case (mode1_reg)
            2'd1: pp_next[0] = pp_raw[0] & ~LOW_H;
            2'd2: begin
                pp_next[0] = '0;
                pp_next[1] = pp_raw[1] & ~LOW_Q;
                pp_next[2] = pp_raw[2] & ~LOW_Q;
            end
            2'd3: begin
                pp_next[0] = '0;
                pp_next[1] = pp_raw[1] & ~LOW_H;
                pp_next[2] = pp_raw[2] & ~LOW_H;
            end
            default: ;
        endcase
    end

    // The sum is bounded by a true W x W product, so 2W bits never overflow.
    assign prod_next = (P'(pp_reg[3]) << W)
                     + ((P'(pp_reg[1]) + P'(pp_reg[2])) << H)
                     + P'(pp_reg[0]);

    assign advance       = bus.out_ready | ~v3_reg;
    assign bus.in_ready  = advance;
    assign bus.out_valid = v3_reg;
    assign bus.prod      = prod_reg;
    assign bus.out_count = count_reg;
    assign bus.busy      = v1_reg | v2_reg | v3_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            v3_reg    <= 1'b0;
            a1_reg    <= '0;
            b1_reg    <= '0;
            mode1_reg <= '0;
            for (int i = 0; i < 4; i++) pp_reg[i] <= '0;
            prod_reg  <= '0;
            count_reg <= '0;
        end else begin
            // Whole pipe moves in lockstep; bubbles travel like data.
            if (advance) begin
                v1_reg    <= bus.in_valid;
                a1_reg    <= bus.a;
                b1_reg    <= bus.b;
                mode1_reg <= bus.mode;
                v2_reg    <= v1_reg;
                for (int i = 0; i < 4; i++) pp_reg[i] <= pp_next[i];
                v3_reg    <= v2_reg;
                prod_reg  <= prod_next;
            end
            if (v3_reg && bus.out_ready) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed bench for approx_mul_pipe: exact and approximate modes, stall
// behaviour, mid-flight reset, and a 16-bit instance with a 4-bit counter.
module tb_approx_mul_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    approx_mul_pipe_if #(.W(8),  .CNT_W(16)) bus8 ();
    approx_mul_pipe_if #(.W(16), .CNT_W(4))  bus16 ();

    approx_mul_pipe #(.W(8), .CNT_W(16)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    approx_mul_pipe #(.W(16), .CNT_W(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [1:0]  vm [4];
    logic [15:0] ve [4];
    logic [15:0] bp_exp [5];

    initial begin
        va[0] = 8'h0F; vb[0] = 8'h0F; vm[0] = 2'd1; ve[0] = 16'd224;
        va[1] = 8'h1F; vb[1] = 8'hF1; vm[1] = 2'd2; ve[1] = 16'd7424;
        va[2] = 8'h1F; vb[2] = 8'hF1; vm[2] = 2'd3; ve[2] = 16'd7424;
        va[3] = 8'hFF; vb[3] = 8'hFF; vm[3] = 2'd2; ve[3] = 16'hFD00;
        for (int i = 0; i < 5; i++) bp_exp[i] = 16'((i + 1) * 3);

        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.mode  = '0; bus8.out_ready  = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.mode = '0; bus16.out_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        chk("rst_busy",      64'(bus8.busy),      64'd0);
        chk("rst_in_ready",  64'(bus8.in_ready),  64'd1);
        chk("rst_prod",      64'(bus8.prod),      64'd0);
        chk("rst_count",     64'(bus8.out_count), 64'd0);
        rst_n = 1'b1;
        step();

        // Exact multiply, latency 3
        bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.mode = 2'd0;
        step();
        bus8.in_valid = 1'b0;
        chk("lat_busy",      64'(bus8.busy),      64'd1);
        step();
        chk("lat_early",     64'(bus8.out_valid), 64'd0);
        step();
        chk("exact_valid",   64'(bus8.out_valid), 64'd1);
        chk("exact_prod",    64'(bus8.prod),      64'hFE01);
        step();
        chk("exact_count",   64'(bus8.out_count), 64'd1);
        chk("exact_drain",   64'(bus8.out_valid), 64'd0);

        // Approximate modes, back to back, one result per cycle
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                bus8.in_valid = 1'b1; bus8.a = va[i]; bus8.b = vb[i]; bus8.mode = vm[i];
            end else begin
                bus8.in_valid = 1'b0;
            end
            step();
            if (i >= 2) begin
                chk("mode_valid", 64'(bus8.out_valid), 64'd1);
                chk("mode_prod",  64'(bus8.prod),      64'(ve[i-2]));
            end
        end
        step();
        chk("mode_count",    64'(bus8.out_count), 64'd5);

        // Back-pressure: fill the pipe with out_ready low
        bus8.out_ready = 1'b0;
        bus8.mode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            bus8.in_valid = 1'b1; bus8.a = 8'(i + 1); bus8.b = 8'd3;
            step();
        end
        bus8.a = 8'd4;
        #1;
        chk("bp_in_ready",   64'(bus8.in_ready),  64'd0);
        step(); step();
        chk("bp_hold_valid", 64'(bus8.out_valid), 64'd1);
        chk("bp_hold_prod",  64'(bus8.prod),      64'(bp_exp[0]));
        chk("bp_hold_count", 64'(bus8.out_count), 64'd5);
        bus8.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                bus8.in_valid = 1'b1; bus8.a = 8'd4;
            end else if (k == 1) begin
                bus8.in_valid = 1'b1; bus8.a = 8'd5;
            end else begin
                bus8.in_valid = 1'b0;
            end
            #1;
            chk("bp_valid", 64'(bus8.out_valid), 64'd1);
            chk("bp_prod",  64'(bus8.prod),      64'(bp_exp[k]));
            step();
        end
        chk("bp_drain",      64'(bus8.out_valid), 64'd0);
        chk("bp_count",      64'(bus8.out_count), 64'd10);

        // Reset with two pairs in flight
        bus8.in_valid = 1'b1; bus8.a = 8'd7; bus8.b = 8'd9;
        step();
        bus8.a = 8'd11;
        step();
        bus8.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus8.out_valid), 64'd0);
        chk("mid_rst_prod",  64'(bus8.prod),      64'd0);
        chk("mid_rst_count", 64'(bus8.out_count), 64'd0);
        chk("mid_rst_busy",  64'(bus8.busy),      64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_idle", 64'(bus8.out_valid), 64'd0);
        end

        // 16-bit exact multiply and 4-bit counter wrap after 17 results
        for (int i = 0; i < 19; i++) begin
            if (i == 0) begin
                bus16.in_valid = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF;
            end else if (i < 17) begin
                bus16.in_valid = 1'b1; bus16.a = 16'd1; bus16.b = 16'd1;
            end else begin
                bus16.in_valid = 1'b0;
            end
            step();
            if (i == 2) chk("w16_prod", 64'(bus16.prod), 64'hFFFE0001);
            if (i == 3) chk("w16_next", 64'(bus16.prod), 64'd1);
        end
        step(); step(); step();
        chk("w16_drain",     64'(bus16.out_valid), 64'd0);
        chk("w16_wrap",      64'(bus16.out_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
